ps2_mouse_rx: RTL and testbench
===============================

// Module: ps2_mouse_rx
// PURPOSE
//  Receive-only PS/2 mouse front end, directly upstream of the Nios II PS/2 interface / PIO display path.
//  Synchronises and de-glitches PS2_CLK/PS2_DAT, deserialises 11-bit device-to-host frames,
//  checks framing and parity, and assembles 3-byte (standard) or 4-byte (IntelliMouse wheel) packets.
//  Decoded button/X/Y/wheel values are then available to software as one-cycle-strobed registers.
// PARAMETERS
//  FILT      4       filtered PS2_CLK changes only after FILT consecutive equal synced samples (range 2..15)
//  TOUT_CYC  100000  CLK cycles without a filtered PS2_CLK edge before timeout (2 ms at 50 MHz)
//  WHEEL     1       1: 4-byte packets with Z; 0: 3-byte packets, DZ forced to 0
// PORTS
//  CLK        in   1  system clock (50 MHz)
//  RST_N      in   1  asynchronous active-low reset
//  PS2_CLK_I  in   1  raw PS/2 clock line (input side of the open-drain pad)
//  PS2_DAT_I  in   1  raw PS/2 data line
//  BYTE_DATA  out  8  last good received byte; held until the next good byte
//  BYTE_VLD   out  1  1-cycle pulse per good byte
//  FRAME_ERR  out  1  1-cycle pulse on a parity, stop-bit or timeout error
//  ERR_CNT    out  8  frame-error count, saturates at 255
//  PKT_VLD    out  1  1-cycle pulse when a complete packet is decoded
//  BTN        out  3  {middle,right,left}, from byte0[2:0]
//  DX         out  9  signed two's complement {b0[4],b1}
//  DY         out  9  signed two's complement {b0[5],b2}
//  DZ         out  4  signed two's complement b3[3:0]; 0 when WHEEL=0
//  OVF        out  2  {Y overflow b0[7], X overflow b0[6]}
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; synced/filtered clock and data = 1; packet index = 0; timeout counter = 0.
//  Input path: 2-FF synchroniser on each input -> filter -> falling edge of filtered clock = bit strobe.
//   Data bit is the filtered data value at the strobe cycle.
//  Frame FSM: IDLE -> DATA (8 bits, LSB first) -> PAR -> STOP -> IDLE.
//   IDLE: strobe with data=0 -> DATA; strobe with data=1 is ignored.
//   STOP strobe: good if stop=1 and XOR(d[7:0],par)=1 (odd parity).
//   Good frame: BYTE_DATA/BYTE_VLD updated in the cycle after the stop strobe (latency 1).
//   Bad frame: FRAME_ERR pulse; ERR_CNT+1 (saturating); byte discarded; packet index -> 0.
//  Timeout: counter clears on every filtered clock edge (either direction) and otherwise counts up, saturating.
//   At TOUT_CYC with FSM not IDLE: FSM -> IDLE, FRAME_ERR pulse, ERR_CNT+1, packet index -> 0.
//   At TOUT_CYC with FSM IDLE and index!=0: index -> 0 silently, with no error.
//  Packet assembler: NB = 3+WHEEL; index 0..NB-1, advances on each good byte.
//   Index 0 accepts only bytes with bit3=1 (sync bit). Any other byte gives BYTE_VLD but is dropped;
//    the index stays 0 and no error is raised.
//   Byte at index NB-1: PKT_VLD pulses in the same cycle as its BYTE_VLD;
//    BTN/DX/DY/DZ/OVF update in that cycle and hold until the next packet; index -> 0.
//  Simultaneous events: timeout and strobe cannot coincide, because a strobe clears the counter first.
//   An error in the same cycle as a good-byte index advance cannot occur (the FSM is single-path).
//  ERR_CNT at 255 stays 255; FRAME_ERR still pulses.
//  RST_N assertion mid-frame or mid-packet: partial data dropped; outputs return to reset values immediately.
// TESTING
//  1 WHEEL=1, send 0x29,0x05,0xFB,0x0F at 12.5 kHz bit rate -> 4 BYTE_VLD pulses, 1 PKT_VLD;
//    BTN=3'b001, DX=9'h005, DY=9'h1FB (-5), DZ=4'hF (-1), OVF=0.
//  2 Send byte 0x09 with even parity -> FRAME_ERR pulse, ERR_CNT=1, no BYTE_VLD;
//    next full packet 0x08,0x01,0x02,0x00 decodes DX=1, DY=2.
//  3 PS2_CLK low glitch of FILT-1 cycles during DATA -> no bit consumed;
//    the frame completes correctly with byte 0xA5.
//  4 Hold both lines high after 5 data bits for TOUT_CYC+10 cycles -> exactly 1 FRAME_ERR, FSM IDLE;
//    the following packet decodes.
//  5 Send 0x00 then an aligned 0x08,0x10,0x20,0x01 -> 5 BYTE_VLD, 1 PKT_VLD;
//    DX=9'h010, DY=9'h020, DZ=1.
//  6 Assert RST_N low after byte 2 of a packet with ERR_CNT=3 -> all outputs 0, ERR_CNT=0;
//    after release, a fresh packet decodes.

Source files
------------

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receive front end: input synchronisation and de-glitching,
// 11-bit frame deserialisation with parity/stop checking, frame timeout,
// and assembly of 3- or 4-byte mouse packets into strobed registers.
module ps2_mouse_rx #(
  parameter int FILT     = 4,
  parameter int TOUT_CYC = 100000,
  parameter int WHEEL    = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2_CLK_I,
  input  logic       PS2_DAT_I,
  output logic [7:0] BYTE_DATA,
  output logic       BYTE_VLD,
  output logic       FRAME_ERR,
  output logic [7:0] ERR_CNT,
  output logic       PKT_VLD,
  output logic [2:0] BTN,
  output logic [8:0] DX,
  output logic [8:0] DY,
  output logic [3:0] DZ,
  output logic [1:0] OVF
);

  localparam int              NB       = 3 + WHEEL;
  localparam int              TW       = $clog2(TOUT_CYC + 1);
  localparam logic [1:0]      LAST_IDX = 2'(NB - 1);
  localparam logic [3:0]      FILT_LIM = 4'(FILT - 1);
  localparam logic [TW-1:0]   TOUT_LIM = TW'(TOUT_CYC - 1);
  localparam logic [TW-1:0]   TOUT_MAX = TW'(TOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]    clk_sync_p0, dat_sync_p0;
  logic          filt_clk_p1, filt_dat_p1;
  logic [3:0]    fcnt_clk, fcnt_dat;
  logic          filt_clk_d_p2;
  logic          bit_stb, clk_edge, tout_hit;
  logic [TW-1:0] tout_cnt;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_bit;
  logic [1:0] idx;
  logic [6:0] hdr;     // byte0 without its sync bit: {ovf_y, ovf_x, sy, sx, btn[2:0]}
  logic [7:0] b1, b2;
  logic [7:0] y_byte;
  logic [3:0] z_val;

  // ---- stage p0: two-flop synchronisers on both raw lines
  // Synchronise raw lines into the CLK domain; idle level is high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync_p0 <= 2'b11;
      dat_sync_p0 <= 2'b11;
    end else begin
      clk_sync_p0 <= {clk_sync_p0[0], PS2_CLK_I};
      dat_sync_p0 <= {dat_sync_p0[0], PS2_DAT_I};
    end
  end

  // ---- stage p1: glitch filters (value changes after FILT consecutive differing samples)
  // Clock filter: a run shorter than FILT samples never reaches the output.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      filt_clk_p1 <= 1'b1;
      fcnt_clk    <= '0;
    end else if (clk_sync_p0[1] == filt_clk_p1) begin
      fcnt_clk <= '0;
    end else if (fcnt_clk == FILT_LIM) begin
      filt_clk_p1 <= clk_sync_p0[1];
      fcnt_clk    <= '0;
    end else begin
      fcnt_clk <= fcnt_clk + 4'd1;
    end
  end

  // Data filter with the same delay so data keeps its setup margin to the clock edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      filt_dat_p1 <= 1'b1;
      fcnt_dat    <= '0;
    end else if (dat_sync_p0[1] == filt_dat_p1) begin
      fcnt_dat <= '0;
    end else if (fcnt_dat == FILT_LIM) begin
      filt_dat_p1 <= dat_sync_p0[1];
      fcnt_dat    <= '0;
    end else begin
      fcnt_dat <= fcnt_dat + 4'd1;
    end
  end

  // ---- stage p2: edge detection on the filtered clock
  // Delayed copy of the filtered clock for edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) filt_clk_d_p2 <= 1'b1;
    else        filt_clk_d_p2 <= filt_clk_p1;
  end

  assign bit_stb  = filt_clk_d_p2 & ~filt_clk_p1;
  assign clk_edge = filt_clk_d_p2 ^ filt_clk_p1;
  assign tout_hit = ~clk_edge & (tout_cnt == TOUT_LIM);

  // Cycles since the last filtered clock edge; fires tout_hit once, then saturates.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                    tout_cnt <= '0;
    else if (clk_edge)             tout_cnt <= '0;
    else if (tout_cnt != TOUT_MAX) tout_cnt <= tout_cnt + TW'(1);
  end

  // Final packet byte is still in shreg when the packet completes.
  assign y_byte = (WHEEL != 0) ? b2 : shreg;
  assign z_val  = (WHEEL != 0) ? shreg[3:0] : 4'd0;

  // Frame FSM, error accounting and packet assembly with registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      idx       <= '0;
      hdr       <= '0;
      b1        <= '0;
      b2        <= '0;
      BYTE_DATA <= '0;
      BYTE_VLD  <= 1'b0;
      FRAME_ERR <= 1'b0;
      ERR_CNT   <= '0;
      PKT_VLD   <= 1'b0;
      BTN       <= '0;
      DX        <= '0;
      DY        <= '0;
      DZ        <= '0;
      OVF       <= '0;
    end else begin
      BYTE_VLD  <= 1'b0;
      FRAME_ERR <= 1'b0;
      PKT_VLD   <= 1'b0;
      if (tout_hit) begin
        if (state != S_IDLE) begin
          state     <= S_IDLE;
          FRAME_ERR <= 1'b1;
          ERR_CNT   <= sat_inc8(ERR_CNT);
          idx       <= '0;
        end else if (idx != 2'd0) begin
          idx <= '0;
        end
      end else if (bit_stb) begin
        case (state)
          S_IDLE: begin
            if (!filt_dat_p1) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shreg <= {filt_dat_p1, shreg[7:1]};
            if (bit_cnt == 3'd7) state <= S_PAR;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end
          S_PAR: begin
            par_bit <= filt_dat_p1;
            state   <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            if (filt_dat_p1 && (^{shreg, par_bit})) begin
              BYTE_DATA <= shreg;
              BYTE_VLD  <= 1'b1;
              if (idx == 2'd0) begin
                if (shreg[3]) begin
                  hdr <= {shreg[7:4], shreg[2:0]};
                  idx <= 2'd1;
                end
              end else if (idx == LAST_IDX) begin
                PKT_VLD <= 1'b1;
                BTN     <= hdr[2:0];
                OVF     <= hdr[6:5];
                DX      <= {hdr[3], b1};
                DY      <= {hdr[4], y_byte};
                DZ      <= z_val;
                idx     <= '0;
              end else begin
                if (idx == 2'd1) b1 <= shreg;
                else             b2 <= shreg;
                idx <= idx + 2'd1;
              end
            end else begin
              FRAME_ERR <= 1'b1;
              ERR_CNT   <= sat_inc8(ERR_CNT);
              idx       <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: drives PS/2 frames, predicts each output event
// from packet-level arithmetic, and compares DUT outputs every cycle.
module tb_ps2_mouse_rx;

  localparam int FILT = 4;
  localparam int TOUT = 1000;
  localparam int NB   = 4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       PS2_CLK_I = 1'b1;
  logic       PS2_DAT_I = 1'b1;
  logic [7:0] BYTE_DATA;
  logic       BYTE_VLD;
  logic       FRAME_ERR;
  logic [7:0] ERR_CNT;
  logic       PKT_VLD;
  logic [2:0] BTN;
  logic [8:0] DX;
  logic [8:0] DY;
  logic [3:0] DZ;
  logic [1:0] OVF;

  ps2_mouse_rx #(.FILT(FILT), .TOUT_CYC(TOUT), .WHEEL(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .PS2_CLK_I(PS2_CLK_I), .PS2_DAT_I(PS2_DAT_I),
    .BYTE_DATA(BYTE_DATA), .BYTE_VLD(BYTE_VLD), .FRAME_ERR(FRAME_ERR),
    .ERR_CNT(ERR_CNT), .PKT_VLD(PKT_VLD), .BTN(BTN), .DX(DX), .DY(DY),
    .DZ(DZ), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         is_err;
    logic [7:0] byte_v;
    bit         pkt;
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [3:0] dz;
    logic [1:0] ovf;
    logic [7:0] errc;
  } ev_t;

  ev_t expq[$];

  int checks = 0;
  int errors = 0;

  // packet-level model state
  logic [7:0] pkt_b [0:3];
  int pkt_n = 0;
  int m_err = 0;
  int half  = 20;

  // values the outputs must currently hold
  logic [7:0] h_byte = '0;
  logic [2:0] h_btn  = '0;
  logic [8:0] h_dx   = '0;
  logic [8:0] h_dy   = '0;
  logic [3:0] h_dz   = '0;
  logic [1:0] h_ovf  = '0;
  logic [7:0] h_err  = '0;
  int n_bvld = 0;
  int n_pkt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic model_good(input logic [7:0] b);
    ev_t e;
    int dx, dy, dz;
    e.is_err = 0; e.byte_v = b; e.pkt = 0;
    e.btn = h_btn; e.dx = 0; e.dy = 0; e.dz = 0; e.ovf = 0;
    e.errc = m_err[7:0];
    if (!(pkt_n == 0 && b[3] == 1'b0)) begin
      pkt_b[pkt_n] = b;
      pkt_n++;
      if (pkt_n == NB) begin
        dx = int'(pkt_b[1]) - (pkt_b[0][4] ? 256 : 0);
        dy = int'(pkt_b[2]) - (pkt_b[0][5] ? 256 : 0);
        dz = int'(pkt_b[3] & 8'h0F) - (pkt_b[3][3] ? 16 : 0);
        e.pkt = 1;
        e.btn = pkt_b[0][2:0];
        e.dx  = dx[8:0];
        e.dy  = dy[8:0];
        e.dz  = dz[3:0];
        e.ovf = {pkt_b[0][7], pkt_b[0][6]};
        pkt_n = 0;
      end
    end
    expq.push_back(e);
  endtask

  task automatic model_err();
    ev_t e;
    m_err = (m_err < 255) ? m_err + 1 : 255;
    e.is_err = 1; e.byte_v = 0; e.pkt = 0;
    e.btn = 0; e.dx = 0; e.dy = 0; e.dz = 0; e.ovf = 0;
    e.errc = m_err[7:0];
    pkt_n = 0;
    expq.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    if (bad_par || bad_stop) model_err();
    else                     model_good(b);
    for (int i = 0; i < 11; i++) begin
      PS2_DAT_I = fr[i];
      if (glitch && i == 4) begin
        tick(5);
        PS2_CLK_I = 1'b0;
        tick(FILT - 1);
        PS2_CLK_I = 1'b1;
        tick(half - 5 - (FILT - 1));
      end else begin
        tick(half);
      end
      PS2_CLK_I = 1'b0;
      tick(half);
      PS2_CLK_I = 1'b1;
    end
    PS2_DAT_I = 1'b1;
    tick(4 * half);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0);
  endtask

  // start bit plus five data bits, then both lines left high
  task automatic send_partial(input logic [7:0] b);
    logic [10:0] fr;
    fr = {2'b11, b, 1'b0};
    model_err();
    for (int i = 0; i < 6; i++) begin
      PS2_DAT_I = fr[i];
      tick(half);
      PS2_CLK_I = 1'b0;
      tick(half);
      PS2_CLK_I = 1'b1;
    end
    PS2_DAT_I = 1'b1;
    tick(TOUT + 50);
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && expq.size() != 0; k++) tick(1);
    chk("drain_pending_events", 64'(expq.size()), 64'd0);
  endtask

  // One compare process: pulses against the predicted event queue, held values every cycle.
  always @(negedge CLK) begin
    ev_t e;
    if (RST_N === 1'b0) begin
      chk("reset_outputs",
          {BYTE_DATA, BYTE_VLD, FRAME_ERR, ERR_CNT, PKT_VLD, BTN, DX, DY, DZ, OVF}, 64'd0);
      h_byte = '0; h_btn = '0; h_dx = '0; h_dy = '0; h_dz = '0; h_ovf = '0; h_err = '0;
    end else if (RST_N === 1'b1) begin
      if (BYTE_VLD || FRAME_ERR || PKT_VLD) begin
        if (BYTE_VLD) n_bvld++;
        if (PKT_VLD)  n_pkt++;
        if (expq.size() == 0) begin
          chk("unexpected_pulse", {BYTE_VLD, FRAME_ERR, PKT_VLD}, 64'd0);
        end else begin
          e = expq.pop_front();
          chk("pulses", {BYTE_VLD, FRAME_ERR, PKT_VLD}, {~e.is_err, e.is_err, e.pkt});
          if (!e.is_err) h_byte = e.byte_v;
          if (e.pkt) begin
            h_btn = e.btn; h_dx = e.dx; h_dy = e.dy; h_dz = e.dz; h_ovf = e.ovf;
          end
          h_err = e.errc;
        end
      end
      chk("held_outputs", {BYTE_DATA, BTN, DX, DY, DZ, OVF, ERR_CNT},
          {h_byte, h_btn, h_dx, h_dy, h_dz, h_ovf, h_err});
    end
  end

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: bench did not finish, got %0d checks, expected completion", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0, p0;
    logic [7:0] rb;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    tick(5);
    RST_N = 1'b1;
    tick(20);

    // standard wheel packet
    b0 = n_bvld; p0 = n_pkt;
    send_good(8'h29); send_good(8'h05); send_good(8'hFB); send_good(8'h0F);
    drain();
    chk("t1_byte_vld_count", 64'(n_bvld - b0), 64'd4);
    chk("t1_pkt_vld_count", 64'(n_pkt - p0), 64'd1);
    chk("t1_btn", BTN, 3'b001);
    chk("t1_dx", DX, 9'h005);
    chk("t1_dy", DY, 9'h1FB);
    chk("t1_dz", DZ, 4'hF);
    chk("t1_ovf", OVF, 2'b00);

    // even parity is rejected
    b0 = n_bvld;
    send_frame(8'h09, 1'b1, 1'b0, 1'b0);
    drain();
    chk("t2_err_cnt", ERR_CNT, 8'd1);
    chk("t2_no_byte_vld", 64'(n_bvld - b0), 64'd0);
    send_good(8'h08); send_good(8'h01); send_good(8'h02); send_good(8'h00);
    drain();
    chk("t2_dx", DX, 9'h001);
    chk("t2_dy", DY, 9'h002);

    // short clock glitch mid-frame
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    drain();
    chk("t3_byte", BYTE_DATA, 8'hA5);

    // abandoned frame times out once
    send_partial(8'h5A);
    drain();
    chk("t4_err_cnt", ERR_CNT, 8'd2);
    send_good(8'h18); send_good(8'h03); send_good(8'hFD); send_good(8'h02);
    drain();
    chk("t4_dx", DX, 9'h103);
    chk("t4_dy", DY, 9'h0FD);

    // unaligned byte dropped before sync
    b0 = n_bvld; p0 = n_pkt;
    send_good(8'h00);
    send_good(8'h08); send_good(8'h10); send_good(8'h20); send_good(8'h01);
    drain();
    chk("t5_byte_vld_count", 64'(n_bvld - b0), 64'd5);
    chk("t5_pkt_vld_count", 64'(n_pkt - p0), 64'd1);
    chk("t5_dx", DX, 9'h010);
    chk("t5_dy", DY, 9'h020);
    chk("t5_dz", DZ, 4'h1);

    // bad stop bit
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    drain();
    chk("stop_err_cnt", ERR_CNT, 8'd3);

    // idle gap mid-packet silently restarts assembly
    p0 = n_pkt;
    send_good(8'h08); send_good(8'h01);
    tick(TOUT + 100);
    pkt_n = 0;
    send_good(8'h08); send_good(8'h11); send_good(8'h22); send_good(8'h03);
    drain();
    chk("idle_pkt_count", 64'(n_pkt - p0), 64'd1);
    chk("idle_dx", DX, 9'h011);
    chk("idle_dy", DY, 9'h022);
    chk("idle_err_cnt", ERR_CNT, 8'd3);

    // reset mid-packet
    send_good(8'h28); send_good(8'h7F);
    drain();
    chk("t6_err_before", ERR_CNT, 8'd3);
    RST_N = 1'b0;
    pkt_n = 0; m_err = 0;
    tick(3);
    chk("t6_err_in_reset", ERR_CNT, 8'd0);
    chk("t6_dx_in_reset", DX, 9'd0);
    RST_N = 1'b1;
    tick(10);
    send_good(8'h09); send_good(8'h02); send_good(8'h03); send_good(8'h0E);
    drain();
    chk("t6_dx", DX, 9'h002);
    chk("t6_dy", DY, 9'h003);
    chk("t6_dz", DZ, 4'hE);

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      if (pkt_n == 0 && $urandom_range(0, 3) != 0) rb[3] = 1'b1;
      send_frame(rb, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0);
    end
    drain();

    // error counter saturation at a faster bit rate
    half = 6;
    while (m_err < 255) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    drain();
    chk("sat_err_cnt", ERR_CNT, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
